// File: rtl/bitty_core_pkg.sv
// Shared types and instruction field positions for the bitty_core accumulator CPU.
package bitty_core_pkg;

  typedef enum logic [1:0] {
    FMT_RR  = 2'b00,
    FMT_RI  = 2'b01,
    FMT_BR  = 2'b10,
    FMT_RSV = 2'b11
  } fmt_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_CMP = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_e;

  localparam logic [1:0] CMP_EQ = 2'd0;
  localparam logic [1:0] CMP_GT = 2'd1;
  localparam logic [1:0] CMP_LT = 2'd2;

  localparam logic [1:0] COND_EQ  = 2'd0;
  localparam logic [1:0] COND_GT  = 2'd1;
  localparam logic [1:0] COND_LT  = 2'd2;
  localparam logic [1:0] COND_ALW = 2'd3;

  localparam int INSTR_W  = 16;
  localparam int FMT_LSB  = 0;
  localparam int OP_LSB   = 2;
  localparam int COND_LSB = 2;
  localparam int TGT_LSB  = 4;
  localparam int IMM_LSB  = 5;
  localparam int RY_LSB   = 10;
  localparam int RX_LSB   = 13;

endpackage

// File: rtl/bitty_alu_w.sv
// Combinational ALU for bitty_core; CMP yields an unsigned 0/1/2 compare code.
module bitty_alu_w
  import bitty_core_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] result
);

  localparam logic [WIDTH-1:0] SHIFT_LIMIT = WIDTH'(WIDTH);

  // The whole B value is the shift amount, so anything at or past WIDTH flushes to zero.
  logic shift_oob;
  assign shift_oob = (b >= SHIFT_LIMIT);

  always_comb begin
    // NOTE: assigning a default before the case keeps this block free of inferred latches.
    result = '0;
    unique case (op)
      OP_ADD: result = a + b;
      OP_SUB: result = a - b;
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: result = shift_oob ? '0 : (a << b);
      OP_SHR: result = shift_oob ? '0 : (a >> b);
      OP_CMP: begin
        if (a == b)     result = WIDTH'(CMP_EQ);
        else if (a > b) result = WIDTH'(CMP_GT);
        else            result = WIDTH'(CMP_LT);
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/bitty_core.sv
// Multi-cycle accumulator-style CPU: IDLE -> DECODE -> [EXEC] -> WB, one instruction per run handshake.
module bitty_core
  import bitty_core_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int REG_COUNT = 8,
  parameter int PC_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [15:0]      d_instr,
  output logic [WIDTH-1:0] d_out,
  output logic [PC_W-1:0]  pc,
  output logic             done,
  output logic             busy
);

  state_e                 state;
  logic [INSTR_W-1:0]     instr;
  logic [WIDTH-1:0]       regs;
  logic [WIDTH-1:0]       regc;
  logic [1:0]             cmp_flag;
  logic [WIDTH-1:0]       rf [REG_COUNT];

  fmt_e                   fmt;
  alu_op_e                op;
  logic [2:0]             rx;
  logic [2:0]             ry;
  logic [1:0]             cond;
  logic [WIDTH-1:0]       imm;
  logic [PC_W-1:0]        target;
  logic [PC_W-1:0]        pc_next;

  assign fmt     = fmt_e'(instr[FMT_LSB +: 2]);
  assign op      = alu_op_e'(instr[OP_LSB +: 3]);
  assign rx      = instr[RX_LSB +: 3];
  assign ry      = instr[RY_LSB +: 3];
  assign cond    = instr[COND_LSB +: 2];
  assign imm     = WIDTH'(instr[IMM_LSB +: 8]);
  assign target  = instr[TGT_LSB +: PC_W];
  assign pc_next = pc + PC_W'(1);

  // Indices past REG_COUNT match no entry: reads give zero, writes fall through.
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (rx == 3'(i)) rd_a = rf[i];
      if (ry == 3'(i)) rd_b = rf[i];
    end
  end

  logic [WIDTH-1:0] b_operand;
  logic [WIDTH-1:0] alu_result;
  assign b_operand = (fmt == FMT_RI) ? imm : rd_b;

  bitty_alu_w #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a     (regs),
    .b     (b_operand),
    .op    (op),
    .result(alu_result)
  );

  logic br_taken;
  always_comb begin
    br_taken = 1'b0;
    unique case (cond)
      COND_EQ:  br_taken = (cmp_flag == CMP_EQ);
      COND_GT:  br_taken = (cmp_flag == CMP_GT);
      COND_LT:  br_taken = (cmp_flag == CMP_LT);
      COND_ALW: br_taken = 1'b1;
      default:  br_taken = 1'b0;
    endcase
  end

  assign d_out = regc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      instr    <= '0;
      regs     <= '0;
      regc     <= '0;
      cmp_flag <= CMP_EQ;
      pc       <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      // NOTE: the register file is architecturally visible and must read as zero after reset,
      // so it is cleared here rather than left as an unreset memory.
      for (int i = 0; i < REG_COUNT; i++) rf[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments everywhere in this block so every branch sees pre-edge values.
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (run) begin
            instr <= d_instr;
            busy  <= 1'b1;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          regs  <= rd_a;
          state <= (fmt == FMT_BR || fmt == FMT_RSV) ? S_WB : S_EXEC;
        end
        S_EXEC: begin
          regc <= alu_result;
          if (op == OP_CMP) cmp_flag <= alu_result[1:0];
          state <= S_WB;
        end
        S_WB: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
          unique case (fmt)
            FMT_RR, FMT_RI: begin
              for (int i = 0; i < REG_COUNT; i++) begin
                if (rx == 3'(i)) rf[i] <= regc;
              end
              pc <= pc_next;
            end
            FMT_BR:  pc <= br_taken ? target : pc_next;
            default: pc <= pc_next;
          endcase
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
